// File: rtl/fifo_packer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_packer_pkg
// Shared types and helpers for the fifo_packer block.
//   packer_state_t : FILL while lanes are being gathered, HOLD while an
//                    assembled word waits for the sink.
//   calc_cntwid()  : width of the out_cnt lane count for a given RATIO.
// -----------------------------------------------------------------------------
package fifo_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

  // Must be able to represent RATIO itself (a full word), not just RATIO-1.
  function automatic int unsigned calc_cntwid(input int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

endpackage

// File: rtl/packer_lane.sv
// -----------------------------------------------------------------------------
// packer_lane
// One WIDTH-bit lane of the fifo_packer assembly register.
// Ports:
//   clk   : clock, all updates on posedge
//   rst   : synchronous active-low reset, clears the lane
//   i_we  : write enable, loads i_d
//   i_clr : synchronous clear to zero
//   i_d   : write data
//   o_q   : lane contents
// A write takes priority over a clear: a word acceptance clears every lane, but
// the entry popped in that same cycle must land in the freshly cleared lane 0.
// -----------------------------------------------------------------------------
module packer_lane #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end else if (i_clr) begin
      r_q <= '0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fifo_packer.sv
// -----------------------------------------------------------------------------
// fifo_packer
// Pops RATIO consecutive WIDTH-bit entries from a narrow FIFO head and presents
// them as one WIDTH*RATIO-bit word on a valid/ready stream. Lane 0 holds the
// first entry popped. While a word waits in HOLD, pops stall unless the sink
// accepts in the same cycle, in which case the new entry lands in lane 0.
//
// Optional feature macro: PARTIAL_FLUSH_EN
//   When defined, adds the flush input and the out_cnt output so a partially
//   filled word can be emitted; out_cnt reports the number of valid lanes.
//
// Ports:
//   clk        : clock, all state updates on posedge
//   rst        : synchronous active-low reset
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head entry (combinational)
//   fifo_pop   : FIFO pop, combinational, depends on out_ready this cycle
//   out_valid  : assembled word available
//   out_ready  : sink accepts the word
//   out_data   : assembled word, lane k at [k*WIDTH +: WIDTH]
//   out_cnt    : valid lane count   (PARTIAL_FLUSH_EN only)
//   flush      : emit partial word  (PARTIAL_FLUSH_EN only)
// -----------------------------------------------------------------------------
module fifo_packer
  import fifo_packer_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RATIO  = 4
`ifdef PARTIAL_FLUSH_EN
  ,
  parameter int unsigned CNTWID = calc_cntwid(RATIO)
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_pop,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef PARTIAL_FLUSH_EN
  output logic [CNTWID-1:0]      out_cnt,
  input  logic                   flush,
`endif
  output logic [WIDTH*RATIO-1:0] out_data
);

  localparam int unsigned IDXW = $clog2(RATIO);

  packer_state_t    r_state;
  packer_state_t    w_state_d;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW-1:0]  w_idx_d;
  logic [IDXW-1:0]  w_wr_idx;
  logic             w_accept;
  logic             w_word_done;
  logic [WIDTH-1:0] w_lane_q [RATIO];

`ifdef PARTIAL_FLUSH_EN
  logic              w_flush;
  logic [CNTWID-1:0] r_cnt;
  logic [CNTWID-1:0] w_cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Handshake, pop and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = (r_state == HOLD);
    w_accept  = (r_state == HOLD) & out_ready;
    // In HOLD a pop is only allowed when the held word leaves this same cycle.
    fifo_pop  = rst & ~fifo_empty & ((r_state == FILL) | out_ready);
    // On an accepting cycle the register is being cleared, so a concurrent pop
    // restarts at lane 0 regardless of r_idx.
    w_wr_idx    = w_accept ? '0 : r_idx;
    w_word_done = fifo_pop & (r_state == FILL) & (r_idx == IDXW'(RATIO - 1));

    w_state_d = r_state;
    w_idx_d   = r_idx;
`ifdef PARTIAL_FLUSH_EN
    w_flush = flush & (r_state == FILL) & (r_idx != '0) & ~fifo_pop;
    w_cnt_d = r_cnt;
`endif

    if (w_accept) begin
      w_state_d = FILL;
      w_idx_d   = fifo_pop ? IDXW'(1) : '0;
`ifdef PARTIAL_FLUSH_EN
      w_cnt_d   = '0;
`endif
    end else if (w_word_done) begin
      w_state_d = HOLD;
      w_idx_d   = '0;
`ifdef PARTIAL_FLUSH_EN
      w_cnt_d   = CNTWID'(RATIO);
`endif
    end else if (fifo_pop) begin
      w_idx_d = r_idx + IDXW'(1);
`ifdef PARTIAL_FLUSH_EN
    end else if (w_flush) begin
      // Unwritten lanes were cleared at the last accept/reset, so they read 0.
      w_state_d = HOLD;
      w_idx_d   = '0;
      w_cnt_d   = CNTWID'(r_idx);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= FILL;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
    end
  end

`ifdef PARTIAL_FLUSH_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign out_cnt = r_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Assembly register, one lane per FIFO entry
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    packer_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .i_we (fifo_pop & (w_wr_idx == IDXW'(k))),
      .i_clr(w_accept),
      .i_d  (fifo_data),
      .o_q  (w_lane_q[k])
    );

    assign out_data[k*WIDTH +: WIDTH] = w_lane_q[k];
  end

endmodule

// File: tb/tb_fifo_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_packer
// Self-checking bench for fifo_packer (WIDTH=8, RATIO=4). A queue models the
// upstream FIFO; each word loaded into it pushes its expected assembly onto a
// scoreboard, which is popped and compared whenever the DUT hands a word over.
// -----------------------------------------------------------------------------
module tb_fifo_packer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned RATIO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_data;
  logic              fifo_pop;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
`ifdef PARTIAL_FLUSH_EN
  logic [2:0]        out_cnt;
  logic              flush;
`endif

  always #5 clk = ~clk;

  fifo_packer #(
    .WIDTH(WIDTH),
    .RATIO(RATIO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PARTIAL_FLUSH_EN
    .out_cnt   (out_cnt),
    .flush     (flush),
`endif
    .out_data  (out_data)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  fq[$];
  logic        gap;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // FIFO model outputs
  task automatic drive();
    fifo_empty = gap | (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [2:0] cnt, input int lanes);
    exp_t e;
    for (int i = 0; i < lanes; i++) fq.push_back(w[i*8 +: 8]);
    e.data = w;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  // One clock: sample handshake before the edge, retire the popped entry after.
  task automatic step();
    logic       popped;
    logic       acc;
    exp_t       e;
    logic [7:0] dummy;
    drive();
    #1;
    popped = fifo_pop;
    acc    = out_valid & out_ready;
    if (acc === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("sb_data", 64'(out_data), 64'(e.data));
`ifdef PARTIAL_FLUSH_EN
        check("sb_cnt", 64'(out_cnt), 64'(e.cnt));
`endif
      end
    end
    @(posedge clk);
    #1;
    if (popped === 1'b1 && fq.size() != 0) dummy = fq.pop_front();
    drive();
    #1;
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    gap       = 1'b0;
`ifdef PARTIAL_FLUSH_EN
    flush     = 1'b0;
`endif

    // Reset with a non-empty FIFO and a ready sink
    push_word(32'h44332211, 3'd4, 4);
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rst_pop", 64'(fifo_pop), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
`ifdef PARTIAL_FLUSH_EN
      check("rst_cnt", 64'(out_cnt), 64'd0);
`endif
      step();
    end
    rst = 1'b1;

    // Basic pack
    for (int i = 0; i < 4; i++) begin
      settle();
      check("pack_pop", 64'(fifo_pop), 64'd1);
      step();
    end
    check("pack_valid", 64'(out_valid), 64'd1);
    check("pack_data", 64'(out_data), 64'h44332211);
`ifdef PARTIAL_FLUSH_EN
    check("pack_cnt", 64'(out_cnt), 64'd4);
`endif

    // Backpressure while HOLD with FIFO non-empty
    push_word(32'h88776655, 3'd4, 4);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("bp_pop", 64'(fifo_pop), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'h44332211);
      step();
    end
    out_ready = 1'b1;
    settle();
    check("acc_pop", 64'(fifo_pop), 64'd1);
    step();
    check("acc_valid", 64'(out_valid), 64'd0);
    check("acc_lane0", 64'(out_data), 64'h00000055);
    for (int i = 0; i < 3; i++) step();
    check("bp2_valid", 64'(out_valid), 64'd1);
    check("bp2_data", 64'(out_data), 64'h88776655);
    step();
    check("bp2_drop", 64'(out_valid), 64'd0);

    // Throughput: back-to-back words with no bubble
    push_word(32'h13121110, 3'd4, 4);
    push_word(32'h17161514, 3'd4, 4);
    for (int i = 0; i < 8; i++) begin
      settle();
      check("tp_pop", 64'(fifo_pop), 64'd1);
      step();
    end
    check("tp_valid", 64'(out_valid), 64'd1);
    check("tp_data", 64'(out_data), 64'h17161514);
    step();

    // Empty gaps
    push_word(32'hA4A3A2A1, 3'd4, 4);
    for (int i = 0; i < 8; i++) begin
      gap = (i % 2 == 0);
      settle();
      check("gap_pop", 64'(fifo_pop), 64'(!gap));
      step();
    end
    gap = 1'b0;
    check("gap_valid", 64'(out_valid), 64'd1);
    check("gap_data", 64'(out_data), 64'hA4A3A2A1);
    step();

    // Reset mid-word
    fq.push_back(8'hE1);
    fq.push_back(8'hE2);
    push_word(32'h04030201, 3'd4, 4);
    step();
    step();
    check("mid_part", 64'(out_data), 64'h0000E2E1);
    rst = 1'b0;
    settle();
    check("mid_rst_pop", 64'(fifo_pop), 64'd0);
    step();
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("mid_pop", 64'(fifo_pop), 64'd1);
      step();
    end
    check("mid_valid", 64'(out_valid), 64'd1);
    check("mid_data", 64'(out_data), 64'h04030201);
    step();

`ifdef PARTIAL_FLUSH_EN
    // Partial flush after two entries
    push_word(32'h0000BBAA, 3'd2, 2);
    out_ready = 1'b0;
    step();
    step();
    gap   = 1'b1;
    flush = 1'b1;
    step();
    check("fl_valid", 64'(out_valid), 64'd1);
    check("fl_data", 64'(out_data), 64'h0000BBAA);
    check("fl_cnt", 64'(out_cnt), 64'd2);
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    check("fl_idle_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    gap   = 1'b0;
`endif

    check("sb_drain", 64'(sb.size()), 64'd0);
    check("fifo_drain", 64'(fq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
